// File: rtl/decode_issue_ctrl.sv
// ---------------------------------------------------------------------------
// decode_issue_ctrl
//
// Purpose:
//    Issue controller between fetch and the decode/register-file stage of the
//    RV32I core. Holds one fetched instruction, keeps a per-register busy
//    scoreboard of pending writes plus an in-flight write counter, and only
//    issues when there is no RAW/WAW hazard and the in-flight limit allows it.
//    FENCE/SYSTEM instructions wait until every outstanding write has drained.
//
// Ports:
//    clk               clock
//    rstn              synchronous active-low reset
//    i_fetch_valid     fetched instruction valid
//    o_fetch_ready     controller accepts an instruction this cycle
//    i_fetch_instr     fetched instruction
//    o_issue_valid     held instruction is issuable
//    i_issue_ready     downstream accepts the issue
//    o_issue_instr     held instruction
//    o_issue_rs1_raddr rs1 field of the held instruction
//    o_issue_rs2_raddr rs2 field of the held instruction
//    o_issue_rd_waddr  rd field of the held instruction
//    o_issue_rd_we     held instruction writes a non-zero rd
//    i_wb_valid        a writeback occurs this cycle
//    i_wb_rd_waddr     register being written back
//    i_flush           discard the held (unissued) instruction
//    o_stall           an instruction is held but not issuing
//    o_inflight        outstanding register-write count
//
// Optional feature:
//    DIC_WB_BYPASS_EN  when defined, a writeback in the current cycle is
//                      already visible to the hazard, in-flight-limit and
//                      drain checks, removing one stall cycle.
// ---------------------------------------------------------------------------
module decode_issue_ctrl #(
    parameter int XLEN         = 32,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_fetch_valid,
    output logic            o_fetch_ready,
    input  logic [XLEN-1:0] i_fetch_instr,
    output logic            o_issue_valid,
    input  logic            i_issue_ready,
    output logic [XLEN-1:0] o_issue_instr,
    output logic [4:0]      o_issue_rs1_raddr,
    output logic [4:0]      o_issue_rs2_raddr,
    output logic [4:0]      o_issue_rd_waddr,
    output logic            o_issue_rd_we,
    input  logic            i_wb_valid,
    input  logic [4:0]      i_wb_rd_waddr,
    input  logic            i_flush,
    output logic            o_stall,
    output logic [3:0]      o_inflight
);

    localparam logic [1:0] StEmpty  = 2'd0;
    localparam logic [1:0] StPend   = 2'd1;
    localparam logic [1:0] StSerial = 2'd2;

    localparam logic [3:0] MaxCount = 4'(MAX_INFLIGHT);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [31:0]     busy_q, busy_d;
    logic [3:0]      inflight_q, inflight_d;

    logic [6:0]  opcode;
    logic [4:0]  rs1Addr, rs2Addr, rdAddr;
    logic        rs1Used, rs2Used, rdWe;
    logic        fetchSerial;
    logic [31:0] busyEff;
    logic [3:0]  countEff;
    logic        hazard, canIssue, issueFire, fetchFire;

    // Field decode of the held instruction: which register fields are
    // actually read or written depends only on the major opcode.
    always_comb begin
        opcode  = instr_q[6:0];
        rs1Addr = instr_q[19:15];
        rs2Addr = instr_q[24:20];
        rdAddr  = instr_q[11:7];
        rs1Used = !(opcode == OpLui || opcode == OpAuipc || opcode == OpJal);
        rs2Used = (opcode == OpReg) || (opcode == OpStore) || (opcode == OpBranch);
        rdWe    = !(opcode == OpStore || opcode == OpBranch || opcode == OpFence)
                  && (rdAddr != 5'd0);
        fetchSerial = (i_fetch_instr[6:0] == OpFence) || (i_fetch_instr[6:0] == OpSystem);
    end

    // Busy bits and count as seen by the issue checks. With the bypass the
    // writeback landing this cycle is already folded in.
    always_comb begin
        busyEff  = busy_q;
        countEff = inflight_q;
`ifdef DIC_WB_BYPASS_EN
        if (i_wb_valid) begin
            busyEff[i_wb_rd_waddr] = 1'b0;
            if (inflight_q != 4'd0) begin
                countEff = inflight_q - 4'd1;
            end
        end
`endif
    end

    // Issue decision. A flush withdraws the offer so the handshake cannot
    // complete in the same cycle the instruction is discarded.
    always_comb begin
        hazard = (rs1Used && rs1Addr != 5'd0 && busyEff[rs1Addr])
              || (rs2Used && rs2Addr != 5'd0 && busyEff[rs2Addr])
              || (rdWe && busyEff[rdAddr]);
        canIssue = 1'b0;
        if (state_q == StPend) begin
            canIssue = !hazard && (!rdWe || (countEff < MaxCount));
        end else if (state_q == StSerial) begin
            canIssue = !hazard && (countEff == 4'd0);
        end
        o_issue_valid = canIssue && !i_flush;
        issueFire     = o_issue_valid && i_issue_ready;
        o_fetch_ready = !i_flush && ((state_q == StEmpty) || issueFire);
        fetchFire     = i_fetch_valid && o_fetch_ready;
        o_stall       = (state_q != StEmpty) && !issueFire;
    end

    // Next state and held instruction. Accepting a new instruction while the
    // old one issues gives back-to-back issue with no empty bubble.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        if (i_flush) begin
            state_d = StEmpty;
        end else if (fetchFire) begin
            state_d = fetchSerial ? StSerial : StPend;
            instr_d = i_fetch_instr;
        end else if (issueFire) begin
            state_d = StEmpty;
        end
    end

    // Scoreboard and counter update. The set is applied after the clear so
    // an issue and a writeback to the same register leave it busy.
    always_comb begin
        busy_d = busy_q;
        if (i_wb_valid) begin
            busy_d[i_wb_rd_waddr] = 1'b0;
        end
        if (issueFire && rdWe) begin
            busy_d[rdAddr] = 1'b1;
        end
        busy_d[0] = 1'b0;

        inflight_d = inflight_q;
        if ((issueFire && rdWe) && !(i_wb_valid && inflight_q != 4'd0)) begin
            inflight_d = inflight_q + 4'd1;
        end else if (!(issueFire && rdWe) && (i_wb_valid && inflight_q != 4'd0)) begin
            inflight_d = inflight_q - 4'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StEmpty;
            instr_q    <= '0;
            busy_q     <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
        end
    end

    assign o_issue_instr     = instr_q;
    assign o_issue_rs1_raddr = rs1Addr;
    assign o_issue_rs2_raddr = rs2Addr;
    assign o_issue_rd_waddr  = rdAddr;
    assign o_issue_rd_we     = rdWe;
    assign o_inflight        = inflight_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_decode_issue_ctrl
//
// Purpose:
//    Directed self-checking bench for decode_issue_ctrl (MAX_INFLIGHT = 4).
//    Covers reset, single issue, RAW stall and release, in-flight limit,
//    FENCE drain, flush, set-wins scoreboard update, stray writeback and
//    reset in the middle of operation. Expected timing around writebacks
//    follows DIC_WB_BYPASS_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_decode_issue_ctrl;

    localparam logic [31:0] ADDI_X1   = 32'h0050_0093;
    localparam logic [31:0] ADDI_X2   = 32'h0050_0113;
    localparam logic [31:0] ADDI_X3   = 32'h0050_0193;
    localparam logic [31:0] ADDI_X4   = 32'h0050_0213;
    localparam logic [31:0] ADDI_X5   = 32'h0050_0293;
    localparam logic [31:0] ADD_X2_X1 = 32'h0010_8133;
    localparam logic [31:0] ADD_X2_X3 = 32'h0031_8133;
    localparam logic [31:0] FENCE     = 32'h0000_000F;

    logic        clk;
    logic        rstn;
    logic        fetchValid;
    logic        fetchReady;
    logic [31:0] fetchInstr;
    logic        issueValid;
    logic        issueReady;
    logic [31:0] issueInstr;
    logic [4:0]  rs1Addr, rs2Addr, rdAddr;
    logic        rdWe;
    logic        wbValid;
    logic [4:0]  wbRd;
    logic        flush;
    logic        stall;
    logic [3:0]  inflight;

    int passCount  = 0;
    int totalCount = 0;

    logic [31:0] addiSeq [5];

    decode_issue_ctrl #(.XLEN(32), .MAX_INFLIGHT(4)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .i_fetch_valid     (fetchValid),
        .o_fetch_ready     (fetchReady),
        .i_fetch_instr     (fetchInstr),
        .o_issue_valid     (issueValid),
        .i_issue_ready     (issueReady),
        .o_issue_instr     (issueInstr),
        .o_issue_rs1_raddr (rs1Addr),
        .o_issue_rs2_raddr (rs2Addr),
        .o_issue_rd_waddr  (rdAddr),
        .o_issue_rd_we     (rdWe),
        .i_wb_valid        (wbValid),
        .i_wb_rd_waddr     (wbRd),
        .i_flush           (flush),
        .o_stall           (stall),
        .o_inflight        (inflight)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every input for the coming cycle, then let combinational
    // outputs settle before they are sampled.
    task automatic applyStimulus(input logic fv, input logic [31:0] fi, input logic ir,
                                 input logic wv, input logic [4:0] wr, input logic fl);
        fetchValid = fv;
        fetchInstr = fi;
        issueReady = ir;
        wbValid    = wv;
        wbRd       = wr;
        flush      = fl;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Directed scenario sequence, one step per cycle.
    initial begin
        addiSeq[0] = ADDI_X1;
        addiSeq[1] = ADDI_X2;
        addiSeq[2] = ADDI_X3;
        addiSeq[3] = ADDI_X4;
        addiSeq[4] = ADDI_X5;

        rstn = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        tick();
        checkOutput("reset_issue_valid", 32'(issueValid), 32'd0);
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_inflight", 32'(inflight), 32'd0);
        checkOutput("reset_fetch_ready", 32'(fetchReady), 32'd1);
        checkOutput("reset_instr", issueInstr, 32'h0);
        rstn = 1'b1;

        $display("[TB] single addi x1 issue");
        applyStimulus(1'b1, ADDI_X1, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("t1_fetch_ready", 32'(fetchReady), 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("t1_issue_valid", 32'(issueValid), 32'd1);
        checkOutput("t1_instr", issueInstr, ADDI_X1);
        checkOutput("t1_rd", 32'(rdAddr), 32'd1);
        checkOutput("t1_rd_we", 32'(rdWe), 32'd1);
        checkOutput("t1_rs1", 32'(rs1Addr), 32'd0);
        checkOutput("t1_fetch_ready_held", 32'(fetchReady), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("t1_inflight", 32'(inflight), 32'd1);
        checkOutput("t1_empty_valid", 32'(issueValid), 32'd0);
        checkOutput("t1_empty_ready", 32'(fetchReady), 32'd1);

        $display("[TB] RAW stall on x1");
        applyStimulus(1'b1, ADD_X2_X1, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        checkOutput("t2_valid", 32'(issueValid), 32'd0);
        checkOutput("t2_stall", 32'(stall), 32'd1);
        checkOutput("t2_rs1", 32'(rs1Addr), 32'd1);
        checkOutput("t2_rs2", 32'(rs2Addr), 32'd1);
        checkOutput("t2_rd", 32'(rdAddr), 32'd2);
        tick();
        checkOutput("t2_stall_hold", 32'(stall), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 5'd1, 1'b0);
`ifdef DIC_WB_BYPASS_EN
        checkOutput("t2_valid_wb_cycle", 32'(issueValid), 32'd1);
`else
        checkOutput("t2_valid_wb_cycle", 32'(issueValid), 32'd0);
`endif
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
`ifndef DIC_WB_BYPASS_EN
        checkOutput("t2_valid_after_wb", 32'(issueValid), 32'd1);
        checkOutput("t2_inflight_after_wb", 32'(inflight), 32'd0);
        tick();
`endif
        checkOutput("t2_inflight_issued", 32'(inflight), 32'd1);
        checkOutput("t2_empty_valid", 32'(issueValid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 5'd2, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("t2_inflight_drained", 32'(inflight), 32'd0);

        $display("[TB] in-flight limit with five addi");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, addiSeq[i], 1'b1, 1'b0, 5'd0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        checkOutput("t3_inflight_full", 32'(inflight), 32'd4);
        checkOutput("t3_valid_full", 32'(issueValid), 32'd0);
        checkOutput("t3_stall_full", 32'(stall), 32'd1);
        checkOutput("t3_fetch_ready_full", 32'(fetchReady), 32'd0);
        checkOutput("t3_held_instr", issueInstr, ADDI_X5);
        tick();
        checkOutput("t3_valid_full_hold", 32'(issueValid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 5'd1, 1'b0);
`ifdef DIC_WB_BYPASS_EN
        checkOutput("t3_valid_wb_cycle", 32'(issueValid), 32'd1);
`else
        checkOutput("t3_valid_wb_cycle", 32'(issueValid), 32'd0);
`endif
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
`ifndef DIC_WB_BYPASS_EN
        checkOutput("t3_inflight_after_wb", 32'(inflight), 32'd3);
        checkOutput("t3_valid_after_wb", 32'(issueValid), 32'd1);
        tick();
`endif
        checkOutput("t3_inflight_final", 32'(inflight), 32'd4);
        checkOutput("t3_empty_valid", 32'(issueValid), 32'd0);
        checkOutput("t3_empty_ready", 32'(fetchReady), 32'd1);

        $display("[TB] fence drain");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 5'd2, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 5'd3, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("t4_inflight_two", 32'(inflight), 32'd2);
        applyStimulus(1'b1, FENCE, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        checkOutput("t4_serial_valid", 32'(issueValid), 32'd0);
        checkOutput("t4_serial_stall", 32'(stall), 32'd1);
        checkOutput("t4_fence_rd_we", 32'(rdWe), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 5'd4, 1'b0);
        checkOutput("t4_valid_first_wb", 32'(issueValid), 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 5'd5, 1'b0);
`ifdef DIC_WB_BYPASS_EN
        checkOutput("t4_valid_last_wb", 32'(issueValid), 32'd1);
`else
        checkOutput("t4_valid_last_wb", 32'(issueValid), 32'd0);
`endif
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
`ifndef DIC_WB_BYPASS_EN
        checkOutput("t4_valid_drained", 32'(issueValid), 32'd1);
        tick();
`endif
        checkOutput("t4_inflight_zero", 32'(inflight), 32'd0);
        checkOutput("t4_empty_valid", 32'(issueValid), 32'd0);
        checkOutput("t4_empty_stall", 32'(stall), 32'd0);

        $display("[TB] flush of hazarded add");
        applyStimulus(1'b1, ADDI_X1, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b1, ADD_X2_X1, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        checkOutput("t5_stall_before_flush", 32'(stall), 32'd1);
        applyStimulus(1'b1, ADDI_X5, 1'b1, 1'b0, 5'd0, 1'b1);
        checkOutput("t5_flush_fetch_ready", 32'(fetchReady), 32'd0);
        checkOutput("t5_flush_valid", 32'(issueValid), 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        checkOutput("t5_after_valid", 32'(issueValid), 32'd0);
        checkOutput("t5_after_stall", 32'(stall), 32'd0);
        checkOutput("t5_after_fetch_ready", 32'(fetchReady), 32'd1);
        checkOutput("t5_after_inflight", 32'(inflight), 32'd1);
        applyStimulus(1'b1, ADD_X2_X1, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        checkOutput("t5_x1_still_busy", 32'(issueValid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 5'd1, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("t5_clean_inflight", 32'(inflight), 32'd0);

        $display("[TB] set-wins and stray writeback");
        applyStimulus(1'b1, ADDI_X1, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b1, ADDI_X3, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 5'd3, 1'b0);
        checkOutput("t6_valid_with_wb", 32'(issueValid), 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("t6_inflight_unchanged", 32'(inflight), 32'd1);
        applyStimulus(1'b1, ADD_X2_X3, 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        checkOutput("t6_x3_busy", 32'(issueValid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 5'd1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 5'd3, 1'b0);
        checkOutput("t6_inflight_zero", 32'(inflight), 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("t6_stray_wb", 32'(inflight), 32'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, ADDI_X1, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);
        checkOutput("t7_inflight_before", 32'(inflight), 32'd1);
        checkOutput("t7_waw_valid", 32'(issueValid), 32'd0);
        rstn = 1'b0;
        applyStimulus(1'b1, ADDI_X2, 1'b1, 1'b1, 5'd1, 1'b0);
        tick();
        rstn = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("t7_inflight", 32'(inflight), 32'd0);
        checkOutput("t7_valid", 32'(issueValid), 32'd0);
        checkOutput("t7_stall", 32'(stall), 32'd0);
        checkOutput("t7_instr", issueInstr, 32'h0);
        checkOutput("t7_fetch_ready", 32'(fetchReady), 32'd1);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
